// File: rtl/pc_ctrl.sv
// PC next-address controller: boot vector, redirects, stall, halt/resume.
// Optional interrupt entry/return with saved EPC under `PC_CTRL_IRQ_EN.
module pc_ctrl #(
  parameter int WIDTH = 19,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter logic [WIDTH-1:0] IRQ_VEC = WIDTH'(19'h7FF00)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pc,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             halt,
  input  logic             resume,
  input  logic             irq,
  input  logic             reti,
  output logic             pcwrite,
  output logic [WIDTH-1:0] next_pc,
  output logic             flush,
  output logic             halted,
  output logic             in_isr,
  output logic [WIDTH-1:0] epc
);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALT
  } state_t;

  state_t state_q, state_d;

  logic             redir;
  logic [WIDTH-1:0] tgt;
  logic             irq_ok;
  logic             reti_ok;
  logic [WIDTH-1:0] epc_q;

  assign redir = branch_taken | jump;
  assign tgt   = branch_taken ? branch_target : jump_target;

`ifdef PC_CTRL_IRQ_EN
  logic isr_q;
  logic take_irq;
  logic take_reti;

  assign irq_ok  = irq & ~isr_q;
  assign reti_ok = reti & isr_q;

  assign take_irq = irq_ok &
    (((state_q == RUN) & ~halt) | (state_q == HALT));
  assign take_reti = reti_ok & ~irq_ok & ~halt &
    (state_q == RUN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      isr_q <= 1'b0;
      epc_q <= '0;
    end else if (take_irq) begin
      isr_q <= 1'b1;
      // resume point is where the redirected stream would have gone
      epc_q <= ((state_q == RUN) && redir) ? tgt : pc;
    end else if (take_reti) begin
      isr_q <= 1'b0;
    end
  end

  assign in_isr = isr_q;
  assign epc    = epc_q;
`else
  logic unused_irq;

  assign unused_irq = irq ^ reti;
  assign irq_ok     = 1'b0;
  assign reti_ok    = 1'b0;
  assign epc_q      = '0;
  assign in_isr     = 1'b0;
  assign epc        = '0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= BOOT;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    pcwrite = 1'b0;
    next_pc = pc;
    flush   = 1'b0;
    unique case (state_q)
      BOOT: begin
        pcwrite = 1'b1;
        next_pc = RESET_VEC;
        flush   = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        if (halt) begin
          flush   = 1'b1;
          state_d = HALT;
        end else if (irq_ok) begin
          pcwrite = 1'b1;
          next_pc = IRQ_VEC;
          flush   = 1'b1;
        end else if (reti_ok) begin
          pcwrite = 1'b1;
          next_pc = epc_q;
          flush   = 1'b1;
        end else if (redir) begin
          pcwrite = 1'b1;
          next_pc = tgt;
          flush   = 1'b1;
        end else if (!stall) begin
          pcwrite = 1'b1;
          next_pc = pc + WIDTH'(1);
        end
      end
      HALT: begin
        if (irq_ok) begin
          pcwrite = 1'b1;
          next_pc = IRQ_VEC;
          flush   = 1'b1;
          state_d = RUN;
        end else if (resume) begin
          state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
    // outputs are quiet while reset is held
    if (reset) begin
      pcwrite = 1'b0;
      next_pc = RESET_VEC;
      flush   = 1'b0;
    end
  end

  assign halted = (state_q == HALT);

endmodule

// File: tb/tb_pc_ctrl.sv
// Scoreboard bench for pc_ctrl: directed vectors push expectations,
// a negedge monitor pops and compares every DUT output.
module tb_pc_ctrl;

  localparam logic [18:0] IV = 19'h7FF00;

  logic        clk = 1'b0;
  logic        reset;
  logic [18:0] pc;
  logic        stall, branch_taken, jump;
  logic [18:0] branch_target, jump_target;
  logic        halt, resume, irq, reti;
  logic        pcwrite, flush, halted, in_isr;
  logic [18:0] next_pc, epc;

  pc_ctrl dut (
    .clk(clk),
    .reset(reset),
    .pc(pc),
    .stall(stall),
    .branch_taken(branch_taken),
    .branch_target(branch_target),
    .jump(jump),
    .jump_target(jump_target),
    .halt(halt),
    .resume(resume),
    .irq(irq),
    .reti(reti),
    .pcwrite(pcwrite),
    .next_pc(next_pc),
    .flush(flush),
    .halted(halted),
    .in_isr(in_isr),
    .epc(epc)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        pw;
    logic [18:0] npc;
    logic        fl;
    logic        hl;
    logic        isr;
    logic [18:0] e;
  } exp_t;

  exp_t sbq[$];
  exp_t cur;
  int   total = 0;
  int   bad = 0;

  task automatic push(input string n, input logic pw,
                      input logic [18:0] npc, input logic fl,
                      input logic hl, input logic isr,
                      input logic [18:0] e);
    exp_t x;
    x.name = n;
    x.pw = pw;
    x.npc = npc;
    x.fl = fl;
    x.hl = hl;
    x.isr = isr;
    x.e = e;
    sbq.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    stall = 0;
    branch_taken = 0;
    jump = 0;
    halt = 0;
    resume = 0;
    irq = 0;
    reti = 0;
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      cur = sbq.pop_front();
      total++;
      if ({pcwrite, next_pc, flush, halted, in_isr, epc} !==
          {cur.pw, cur.npc, cur.fl, cur.hl, cur.isr, cur.e}) begin
        bad++;
        $display("FAIL %s: got pw=%0b npc=%h fl=%0b hl=%0b isr=%0b epc=%h want pw=%0b npc=%h fl=%0b hl=%0b isr=%0b epc=%h",
          cur.name, pcwrite, next_pc, flush, halted, in_isr, epc,
          cur.pw, cur.npc, cur.fl, cur.hl, cur.isr, cur.e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1;
    pc = 0;
    stall = 0; branch_taken = 0; jump = 0;
    branch_target = 0; jump_target = 0;
    halt = 0; resume = 0; irq = 0; reti = 0;
    repeat (9) @(posedge clk);

    tick(); push("in_reset", 0, 19'h0, 0, 0, 0, 19'h0);
    tick(); reset = 0; push("boot", 1, 19'h0, 1, 0, 0, 19'h0);
    tick(); pc = 19'h0; push("seq0", 1, 19'h1, 0, 0, 0, 19'h0);
    tick(); pc = 19'h1; push("seq1", 1, 19'h2, 0, 0, 0, 19'h0);
    tick(); pc = 19'h2; push("seq2", 1, 19'h3, 0, 0, 0, 19'h0);

    for (int i = 0; i < 3; i++) begin
      tick(); pc = 19'h10; stall = 1;
      push("stall", 0, 19'h10, 0, 0, 0, 19'h0);
    end
    tick(); pc = 19'h10; push("stall_rel", 1, 19'h11, 0, 0, 0, 19'h0);

    tick(); pc = 19'h20; stall = 1;
    branch_taken = 1; branch_target = 19'h30;
    jump = 1; jump_target = 19'h40;
    push("br_over_jmp", 1, 19'h30, 1, 0, 0, 19'h0);
    tick(); pc = 19'h30; push("flush_pulse", 1, 19'h31, 0, 0, 0, 19'h0);
    tick(); pc = 19'h31; jump = 1; jump_target = 19'h40;
    push("jump", 1, 19'h40, 1, 0, 0, 19'h0);
    tick(); pc = 19'h7FFFF; push("wrap", 1, 19'h0, 0, 0, 0, 19'h0);

`ifndef PC_CTRL_IRQ_EN
    tick(); pc = 19'h50; irq = 1;
    push("irq_off", 1, 19'h51, 0, 0, 0, 19'h0);
    tick(); pc = 19'h51; reti = 1;
    push("reti_off", 1, 19'h52, 0, 0, 0, 19'h0);
`endif

    tick(); pc = 19'h60; halt = 1; resume = 1;
    push("halt_wins", 0, 19'h60, 1, 0, 0, 19'h0);
    for (int i = 0; i < 10; i++) begin
      tick(); pc = 19'h60; branch_taken = (i == 4);
      push("halted", 0, 19'h60, 0, 1, 0, 19'h0);
    end
    tick(); pc = 19'h60; resume = 1;
    push("resume", 0, 19'h60, 0, 1, 0, 19'h0);
    tick(); pc = 19'h60; push("post_resume", 1, 19'h61, 0, 0, 0, 19'h0);
    tick(); pc = 19'h61; halt = 1;
    push("halt2", 0, 19'h61, 1, 0, 0, 19'h0);
    tick(); pc = 19'h61; push("halted2", 0, 19'h61, 0, 1, 0, 19'h0);
    tick(); reset = 1; push("rst_halt", 0, 19'h0, 0, 0, 0, 19'h0);
    tick(); reset = 0; push("reboot", 1, 19'h0, 1, 0, 0, 19'h0);
    tick(); pc = 19'h0; push("reboot_seq", 1, 19'h1, 0, 0, 0, 19'h0);

`ifdef PC_CTRL_IRQ_EN
    tick(); pc = 19'h50; irq = 1; stall = 1;
    push("irq_take", 1, IV, 1, 0, 0, 19'h0);
    tick(); pc = IV; irq = 1;
    push("irq_nest", 1, 19'h7FF01, 0, 0, 1, 19'h50);
    tick(); pc = 19'h7FF01; reti = 1;
    push("reti", 1, 19'h50, 1, 0, 1, 19'h50);
    tick(); pc = 19'h50; push("post_reti", 1, 19'h51, 0, 0, 0, 19'h50);
    tick(); pc = 19'h51; irq = 1;
    branch_taken = 1; branch_target = 19'h90;
    push("irq_br", 1, IV, 1, 0, 0, 19'h50);
    tick(); pc = IV; push("epc_br", 1, 19'h7FF01, 0, 0, 1, 19'h90);
    tick(); reset = 1; push("rst_isr", 0, 19'h0, 0, 0, 0, 19'h0);
    tick(); reset = 0; push("boot3", 1, 19'h0, 1, 0, 0, 19'h0);
    tick(); pc = 19'h0; reti = 1;
    push("reti_noop", 1, 19'h1, 0, 0, 0, 19'h0);
    tick(); pc = 19'h1; halt = 1;
    push("halt3", 0, 19'h1, 1, 0, 0, 19'h0);
    tick(); pc = 19'h1; irq = 1;
    push("irq_halt", 1, IV, 1, 1, 0, 19'h0);
    tick(); pc = IV; push("irq_halt_out", 1, 19'h7FF01, 0, 0, 1, 19'h1);
`endif

    tick();
    repeat (2) @(posedge clk);
    if (sbq.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending want 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_ctrl.md
PC_CTRL -- requirements
Module: pc_ctrl

Interface
REQ-001 Parameter WIDTH, 19, address width of pc/next_pc/targets/epc.
REQ-002 Parameter RESET_VEC, 19'h00000, first fetch address after reset.
REQ-003 Parameter IRQ_VEC, 19'h7FF00, interrupt entry address (used only with IRQ_EN).
REQ-004 clk  in  1  single clock, rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 pc  in  WIDTH  current value of the PC register.
REQ-007 stall  in  1  hazard-unit request to hold the PC.
REQ-008 branch_taken, branch_target  in  1, WIDTH  resolved taken branch and its target.
REQ-009 jump, jump_target  in  1, WIDTH  unconditional jump and its target.
REQ-010 halt, resume  in  1, 1  halt-request pulse and restart pulse.
REQ-011 irq, reti  in  1, 1  interrupt request level and return-from-interrupt pulse.
REQ-012 pcwrite, next_pc  out  1, WIDTH  write enable and value presented to the PC register.
REQ-013 flush  out  1  kill younger pipeline instructions this cycle.
REQ-014 halted, in_isr, epc  out  1, 1, WIDTH  halt status, ISR-active flag, saved return PC.

Function
REQ-015 States SHALL be BOOT, RUN, HALT; state, in_isr and epc registered; pcwrite/next_pc/flush combinational from state and inputs.
REQ-016 BOOT: pcwrite=1, next_pc=RESET_VEC, flush=1; BOOT->RUN unconditionally next cycle.
REQ-017 RUN priority, highest first: halt > irq (REQ-024) > reti (REQ-025) > branch_taken > jump > stall > sequential.
REQ-018 Sequential: pcwrite=1, next_pc=pc+1 modulo 2^WIDTH (19'h7FFFF -> 19'h00000), flush=0.
REQ-019 branch_taken or jump: pcwrite=1, next_pc=selected target, flush=1 same cycle; redirect SHALL override stall.
REQ-020 Both branch_taken and jump high: branch_target SHALL win.
REQ-021 stall with no redirect: pcwrite=0, next_pc=pc, flush=0; held PC for as many cycles as stall is high.
REQ-022 halt in RUN: pcwrite=0, flush=1, RUN->HALT; halted=1 from next cycle.
REQ-023 HALT: pcwrite=0, flush=0; resume -> RUN next cycle, sequential fetch from held pc; halt and resume together in RUN: halt wins.
REQ-024 irq taken in RUN when in_isr=0 (stall ignored): pcwrite=1, next_pc=IRQ_VEC, flush=1, epc<=redirect target if branch_taken/jump else pc, in_isr<=1; irq while in_isr=1 ignored (no nesting).
REQ-025 reti with in_isr=1: pcwrite=1, next_pc=epc, flush=1, in_isr<=0; reti with in_isr=0 treated as no-op (normal priority continues).
REQ-026 irq in HALT with in_isr=0: HALT->RUN, vector taken per REQ-024 with epc<=pc, halted=0 next cycle.
REQ-027 flush SHALL be a single-cycle pulse per redirect event; pcwrite and flush never driven from unregistered feedback of pc (no comb loop with the PC register).

Reset
REQ-028 reset high SHALL immediately force state=BOOT, in_isr=0, epc=0, halted=0, independent of clk.
REQ-029 While reset high: pcwrite=0, next_pc=RESET_VEC, flush=0; BOOT behaviour (REQ-016) begins at first edge after deassertion.
REQ-030 Reset mid-stall, mid-halt or inside an ISR SHALL discard all pending state; no irq/reti effect survives reset.

Configuration
REQ-031 Macro PC_CTRL_IRQ_EN defined: irq, reti, in_isr, epc behave per REQ-024..026.
REQ-032 PC_CTRL_IRQ_EN undefined: irq and reti ignored, in_isr=0 and epc=0 constant, no epc/in_isr registers synthesized, HALT exits only on resume.

Verification
REQ-033 Reset 100 ns, release, pc=0 -> BOOT cycle pcwrite=1 next_pc=0 flush=1, then next_pc=pc+1 each cycle (0x1,0x2,...).
REQ-034 pc=0x10, stall high 3 cycles -> pcwrite=0 for exactly 3 cycles, pc stays 0x10, then next_pc=0x11.
REQ-035 pc=0x20, stall=1 and branch_taken=1, branch_target=0x30, jump=1, jump_target=0x40 -> pcwrite=1, next_pc=0x30, flush=1 one cycle.
REQ-036 pc=0x7FFFF sequential -> next_pc=0x00000, no flush.
REQ-037 IRQ_EN: pc=0x50, irq=1 -> next_pc=0x7FF00, epc=0x50, in_isr=1; second irq ignored; reti -> next_pc=0x50, in_isr=0.
REQ-038 halt pulse at pc=0x60 -> halted=1, pc frozen 10 cycles; reset pulse mid-halt -> halted=0, BOOT, next_pc=0x00000.
